frame_player: RTL and testbench
===============================

FRAME_PLAYER -- requirements
Module: frame_player

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 320: active pixel periods per line.
REQ-002 SHALL have parameter H_BLANK, default 64: blank pixel periods per line, also used as frame lead-in.
REQ-003 SHALL have parameter V_ACTIVE, default 240: active lines per frame.
REQ-004 SHALL have parameter V_BLANK, default 1024: pixel periods of VSYNC-low gap after each frame.
REQ-005 SHALL have parameter PIX_DIV, default 4: clk cycles per pixel period, minimum 2.
REQ-006 SHALL have ports `clk` (input, 1 bit, system clock) and `rst_n` (input, 1 bit, asynchronous active-low reset).
REQ-007 SHALL have port PLAY (input, 1 bit, asynchronous level; high requests continuous frame playback).
REQ-008 SHALL have port SRAM_RD_ADDR (output, 19 bits, read address to the SRAM controller).
REQ-009 SHALL have port SRAM_RD_Q (input, 8 bits, SRAM controller read data, valid at most PIX_DIV-1 cycles after the address changes).
REQ-010 SHALL have port HSYNC (output, 1 bit, high while a line's active pixels are driven).
REQ-011 SHALL have port VSYNC (output, 1 bit, high for the duration of a frame).
REQ-012 SHALL have port PIXEL (output, 8 bits, pixel data).
REQ-013 SHALL have port BUSY (output, 1 bit, high in any state except IDLE).
REQ-014 SHALL have port FRAME_DONE (output, 1 bit, one-clk pulse on entry to VTAIL).

Function
REQ-015 PLAY SHALL pass through a 3-flop synchroniser; decisions SHALL use the synchronised level.
REQ-016 A pixel divider SHALL count 0..PIX_DIV-1 continuously outside IDLE; one wrap SHALL equal one pixel period.
REQ-017 The state machine SHALL have states IDLE, VLEAD, HACT, HBLK and VTAIL.
REQ-018 The IDLE state SHALL drive HSYNC=0, VSYNC=0, PIXEL=0, and SHALL go to VLEAD on the first clk with synchronised PLAY=1, clearing the divider, the line counter and the address to 0.
REQ-019 The VLEAD state SHALL drive VSYNC=1 and HSYNC=0 for H_BLANK pixel periods, then go to HACT.
REQ-020 The HACT state SHALL drive VSYNC=1 and HSYNC=1 for H_ACTIVE pixel periods, then go to HBLK.
REQ-021 The HBLK state SHALL drive VSYNC=1, HSYNC=0 and PIXEL=0 for H_BLANK periods, SHALL increment the line counter at exit, and SHALL go to HACT if the line count is below V_ACTIVE, else to VTAIL.
REQ-022 The VTAIL state SHALL drive VSYNC=0 and HSYNC=0 for V_BLANK periods, then go to VLEAD if PLAY is high (address 0, line 0), else to IDLE.
REQ-023 Deasserting PLAY mid-frame SHALL NOT truncate the frame; the current frame plus its VTAIL SHALL complete.
REQ-024 Prefetch: SRAM_RD_ADDR SHALL present the next pixel's address throughout the pixel period preceding that pixel, and on divider count PIX_DIV-1 of that period PIXEL SHALL load SRAM_RD_Q, giving stable PIXEL for the whole HACT period.
REQ-025 SRAM_RD_ADDR SHALL increment by 1 per HACT pixel and SHALL NOT change in HBLK, so line n+1 continues from line n.
REQ-026 The address SHALL be 19-bit unsigned and SHALL wrap 0x7FFFF to 0 with no error.
REQ-027 Line and pixel counters SHALL be 16-bit; H_ACTIVE*V_ACTIVE > 2^19 SHALL be legal and SHALL wrap per REQ-026.
REQ-028 FRAME_DONE SHALL assert for exactly one clk, coincident with the VSYNC 1-to-0 transition.

Reset
REQ-029 Asserting `rst_n` low SHALL asynchronously force IDLE and clear all outputs, counters and synchroniser flops to 0, including mid-line.
REQ-030 After `rst_n` release, playback SHALL start only via REQ-018; no partial frame SHALL resume.

Configuration
REQ-031 With TEST_PATTERN_EN defined, PIXEL in HACT SHALL be the colour-bar value {pixel_index[5:3], pixel_index[5:3], pixel_index[5:4]} and SRAM_RD_ADDR SHALL still advance.
REQ-032 Without TEST_PATTERN_EN, PIXEL SHALL come only from SRAM_RD_Q per REQ-024.

Structure
REQ-033 Package grabor_pkg SHALL hold the state enum, SRAM_AW=19, PIX_W=8 and default timing constants.
REQ-034 The 3-flop synchroniser SHALL be sub-module sync_edge, reused for PLAY.

Verification
Bench parameters: H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=3, PIX_DIV=4, SRAM model latency 2 with data=addr[7:0].
REQ-035 PLAY pulsed high for 10 clk -> exactly one frame: VSYNC high 2+3*(4+2)=20 periods (80 clk), then BUSY low after 12 clk.
REQ-036 Single frame -> 3 HSYNC pulses of 16 clk each, PIXEL sequence 0..11, PIXEL=0 in all blank periods.
REQ-037 PLAY held high -> VSYNC rises again 12 clk after falling, address restarts 0, FRAME_DONE pulses once per frame.
REQ-038 `rst_n` low during the second line -> all outputs 0 asynchronously; PLAY high after release -> fresh frame from address 0.
REQ-039 Address preloaded to 0x7FFFE by force -> next pixels read 0x7FFFE, 0x7FFFF, 0x00000.
REQ-040 TEST_PATTERN_EN build -> PIXEL follows the bar formula; SRAM_RD_Q ignored.

Source files
------------

// File: rtl/grabor_pkg.sv
// Shared types and constants for the frame player.
// Optional build macro: TEST_PATTERN_EN replaces SRAM pixel data with colour bars.
package grabor_pkg;

  localparam int SRAM_AW = 19;
  localparam int PIX_W   = 8;
  localparam int CNT_W   = 16;

  // Default raster timing (pixel periods / lines)
  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_H_BLANK  = 64;
  localparam int DEF_V_ACTIVE = 240;
  localparam int DEF_V_BLANK  = 1024;
  localparam int DEF_PIX_DIV  = 4;

  typedef enum logic [2:0] {
    IDLE,
    VLEAD,
    HACT,
    HBLK,
    VTAIL
  } state_e;

  // Colour-bar value for a pixel position within a line
  function automatic logic [PIX_W-1:0] bar_pixel(input logic [CNT_W-1:0] idx);
    return {idx[5:3], idx[5:3], idx[5:4]};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Three-flop synchroniser for an asynchronous level input.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  // Shift the raw level in one stage per clock
  always_comb begin
    sync_d = {sync_q[1:0], d};
  end

  // Synchroniser flops, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[2];

endmodule

// File: rtl/frame_player.sv
// Frame player: streams a raster of pixels read from SRAM with HSYNC/VSYNC framing.
// The read address is prefetched one pixel period ahead so PIXEL is stable for a
// whole active period. PIX_DIV must be at least 2.
// Optional build macro: TEST_PATTERN_EN (PIXEL shows colour bars, address still advances).
module frame_player
  import grabor_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_BLANK  = DEF_H_BLANK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_BLANK  = DEF_V_BLANK,
  parameter int PIX_DIV  = DEF_PIX_DIV
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               PLAY,
  output logic [SRAM_AW-1:0] SRAM_RD_ADDR,
  input  logic [PIX_W-1:0]   SRAM_RD_Q,
  output logic               HSYNC,
  output logic               VSYNC,
  output logic [PIX_W-1:0]   PIXEL,
  output logic               BUSY,
  output logic               FRAME_DONE
);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] HACT_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HBLK_LAST = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] VBLK_LAST = CNT_W'(V_BLANK - 1);
  localparam logic [CNT_W-1:0] V_LINES   = CNT_W'(V_ACTIVE);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     div_q, div_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     line_q, line_d;
  logic [SRAM_AW-1:0]   addr_q, addr_d;
  logic [PIX_W-1:0]     pixel_q, pixel_d;
  logic                 frame_done_q, frame_done_d;

  logic                 play_s;
  logic                 tick;
  logic                 load;
  logic [CNT_W-1:0]     line_inc;
  logic [PIX_W-1:0]     load_val;

  sync_edge u_play_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (PLAY),
    .q     (play_s)
  );

  // Last clock of a pixel period
  assign tick     = (div_q == DIV_LAST);
  assign line_inc = line_q + 1'b1;

`ifdef TEST_PATTERN_EN
  // Position within the line of the pixel about to be loaded
  logic [CNT_W-1:0] next_idx;
  assign next_idx = (state_q == HACT) ? cnt_q + 1'b1 : '0;
  assign load_val = bar_pixel(next_idx);
`else
  assign load_val = SRAM_RD_Q;
`endif

  // Next-state, counters and prefetch: a pixel is loaded at the end of every
  // period that is followed by an active pixel, and the address then moves on.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    addr_d       = addr_q;
    pixel_d      = pixel_q;
    frame_done_d = 1'b0;
    load         = 1'b0;

    if (state_q != IDLE) div_d = tick ? '0 : div_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (play_s) begin
          state_d = VLEAD;
          div_d   = '0;
          cnt_d   = '0;
          line_d  = '0;
          addr_d  = '0;
        end
      end
      VLEAD: begin
        if (tick) begin
          if (cnt_q == HBLK_LAST) begin
            state_d = HACT;
            cnt_d   = '0;
            load    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HACT: begin
        if (tick) begin
          if (cnt_q == HACT_LAST) begin
            state_d = HBLK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
            load  = 1'b1;
          end
        end
      end
      HBLK: begin
        if (tick) begin
          if (cnt_q == HBLK_LAST) begin
            cnt_d  = '0;
            line_d = line_inc;
            if (line_inc < V_LINES) begin
              state_d = HACT;
              load    = 1'b1;
            end else begin
              state_d      = VTAIL;
              frame_done_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      VTAIL: begin
        if (tick) begin
          if (cnt_q == VBLK_LAST) begin
            cnt_d = '0;
            if (play_s) begin
              state_d = VLEAD;
              line_d  = '0;
              addr_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      pixel_d = load_val;
      addr_d  = addr_q + 1'b1;
    end
  end

  // State and datapath registers, all cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      div_q        <= '0;
      cnt_q        <= '0;
      line_q       <= '0;
      addr_q       <= '0;
      pixel_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      addr_q       <= addr_d;
      pixel_q      <= pixel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign VSYNC        = (state_q == VLEAD) || (state_q == HACT) || (state_q == HBLK);
  assign HSYNC        = (state_q == HACT);
  assign PIXEL        = HSYNC ? pixel_q : '0;
  assign BUSY         = (state_q != IDLE);
  assign FRAME_DONE   = frame_done_q;
  assign SRAM_RD_ADDR = addr_q;

endmodule

// File: tb/tb_frame_player.sv
// Directed bench for frame_player: 4x3 raster, 2-period blanking, PIX_DIV=4,
// SRAM model with 2-clk latency returning addr[7:0].
module tb_frame_player;

  localparam int CAP = 240;
`ifdef TEST_PATTERN_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PLAY = 1'b0;
  logic [18:0] SRAM_RD_ADDR;
  logic [7:0]  SRAM_RD_Q;
  logic        HSYNC, VSYNC, BUSY, FRAME_DONE;
  logic [7:0]  PIXEL;

  int checks = 0;
  int errors = 0;

  logic        s_vs[CAP], s_hs[CAP], s_busy[CAP], s_fd[CAP];
  logic [7:0]  s_pix[CAP];
  logic [18:0] s_addr[CAP];

  logic [7:0]  a1, a2;

  frame_player #(
    .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3), .V_BLANK(3), .PIX_DIV(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PLAY         (PLAY),
    .SRAM_RD_ADDR (SRAM_RD_ADDR),
    .SRAM_RD_Q    (SRAM_RD_Q),
    .HSYNC        (HSYNC),
    .VSYNC        (VSYNC),
    .PIXEL        (PIXEL),
    .BUSY         (BUSY),
    .FRAME_DONE   (FRAME_DONE)
  );

  always #5 clk = ~clk;

  // SRAM model: data = addr[7:0], two clocks after the address
  always @(posedge clk) begin
    a1 <= SRAM_RD_ADDR[7:0];
    a2 <= a1;
  end
  assign SRAM_RD_Q = a2;

  // Expected PIXEL for an SRAM byte at a given position in the line
  function automatic logic [7:0] exp_pix(input logic [7:0] v, input int pos);
    logic [2:0] p;
    p = 3'(pos >> 3);
    return TP ? {p, p, p[2:1]} : v;
  endfunction

  function automatic int first_vs(input int from, input logic val);
    for (int i = from; i < CAP; i++) if (s_vs[i] === val) return i;
    return CAP - 1;
  endfunction

  function automatic int first_hs(input int from);
    for (int i = from; i < CAP; i++) if (s_hs[i] === 1'b1) return i;
    return CAP - 12;
  endfunction

  // Record outputs at n negedges; drop PLAY after play_len clocks (0 = leave it)
  task automatic capture(input int n, input int play_len);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_vs[i] = VSYNC; s_hs[i] = HSYNC; s_busy[i] = BUSY; s_fd[i] = FRAME_DONE;
      s_pix[i] = PIXEL; s_addr[i] = SRAM_RD_ADDR;
      if (play_len > 0 && i == play_len - 1) PLAY = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (BUSY !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL %s_idle_timeout busy=%b", name, BUSY); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", BUSY); end
    checks++; if (VSYNC !== 1'b0) begin errors++; $display("FAIL rst_vsync got %b want 0", VSYNC); end
    checks++; if (HSYNC !== 1'b0) begin errors++; $display("FAIL rst_hsync got %b want 0", HSYNC); end
    checks++; if (PIXEL !== 8'h00) begin errors++; $display("FAIL rst_pixel got %h want 00", PIXEL); end
    checks++; if (SRAM_RD_ADDR !== 19'h0) begin errors++; $display("FAIL rst_addr got %h want 0", SRAM_RD_ADDR); end
    checks++; if (FRAME_DONE !== 1'b0) begin errors++; $display("FAIL rst_fdone got %b want 0", FRAME_DONE); end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL idle_no_play got busy=%b want 0", BUSY); end
  endtask

  task automatic test_single_frame();
    int v0, vf, vcnt, fdcnt, bcnt, rises, badw, w, k, pbad, bbad, h0;
    logic [7:0] e;
    @(negedge clk); PLAY = 1'b1;
    capture(130, 10);
    v0 = first_vs(0, 1'b1);
    vf = first_vs(v0, 1'b0);
    vcnt = 0; fdcnt = 0; bcnt = 0; rises = 0; badw = 0; w = 0; k = 0; pbad = 0; bbad = 0;
    for (int i = 0; i < 130; i++) begin
      if (s_vs[i]) vcnt++;
      if (s_fd[i]) fdcnt++;
      if (i >= vf && s_busy[i]) bcnt++;
      if (s_hs[i]) begin
        if (i == 0 || !s_hs[i-1]) rises++;
        w++;
        e = exp_pix(8'(k / 4), (k / 4) % 4);
        if (s_pix[i] !== e) pbad++;
        k++;
      end else begin
        if (w != 0 && w != 16) badw++;
        w = 0;
        if (s_pix[i] !== 8'h00) bbad++;
      end
    end
    h0 = first_hs(0);
    checks++; if (v0 !== 3) begin errors++; $display("FAIL play_latency got %0d want 3", v0); end
    checks++; if (vf - v0 !== 80) begin errors++; $display("FAIL vsync_len got %0d want 80", vf - v0); end
    checks++; if (vcnt !== 80) begin errors++; $display("FAIL one_frame vsync clocks got %0d want 80", vcnt); end
    checks++; if (fdcnt !== 1) begin errors++; $display("FAIL fdone_count got %0d want 1", fdcnt); end
    checks++; if (s_fd[vf] !== 1'b1) begin errors++; $display("FAIL fdone_at_vfall got %b want 1", s_fd[vf]); end
    checks++; if (bcnt !== 12) begin errors++; $display("FAIL busy_tail got %0d want 12", bcnt); end
    checks++; if (h0 - v0 !== 8) begin errors++; $display("FAIL lead_in got %0d want 8", h0 - v0); end
    checks++; if (rises !== 3) begin errors++; $display("FAIL hsync_pulses got %0d want 3", rises); end
    checks++; if (badw !== 0) begin errors++; $display("FAIL hsync_width bad=%0d want 0", badw); end
    checks++; if (k !== 48) begin errors++; $display("FAIL hsync_clocks got %0d want 48", k); end
    checks++; if (pbad !== 0) begin errors++; $display("FAIL pixel_seq bad=%0d want 0", pbad); end
    checks++; if (bbad !== 0) begin errors++; $display("FAIL blank_pixel bad=%0d want 0", bbad); end
    wait_idle("single");
  endtask

  task automatic test_back_to_back();
    int v0, vf1, v1, vf2, fdcnt, h;
    @(negedge clk); PLAY = 1'b1;
    capture(200, 0);
    v0  = first_vs(0, 1'b1);
    vf1 = first_vs(v0, 1'b0);
    v1  = first_vs(vf1, 1'b1);
    vf2 = first_vs(v1, 1'b0);
    fdcnt = 0;
    for (int i = 0; i < 200; i++) if (s_fd[i]) fdcnt++;
    h = first_hs(v1);
    checks++; if (v1 - vf1 !== 12) begin errors++; $display("FAIL vsync_gap got %0d want 12", v1 - vf1); end
    checks++; if (vf2 - v1 !== 80) begin errors++; $display("FAIL frame2_len got %0d want 80", vf2 - v1); end
    checks++; if (fdcnt !== 2) begin errors++; $display("FAIL fdone_per_frame got %0d want 2", fdcnt); end
    checks++; if (s_addr[v1] !== 19'h0) begin errors++; $display("FAIL addr_restart got %h want 0", s_addr[v1]); end
    checks++; if (s_pix[h] !== exp_pix(8'h00, 0)) begin errors++; $display("FAIL frame2_pix0 got %h want %h", s_pix[h], exp_pix(8'h00, 0)); end
    checks++; if (s_pix[h+4] !== exp_pix(8'h01, 1)) begin errors++; $display("FAIL frame2_pix1 got %h want %h", s_pix[h+4], exp_pix(8'h01, 1)); end
    PLAY = 1'b0;
    wait_idle("b2b");
  endtask

  task automatic test_addr_wrap();
    int n, h0;
    @(negedge clk); PLAY = 1'b1;
    n = 0;
    while (VSYNC !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (VSYNC !== 1'b1) begin errors++; $display("FAIL wrap_start_timeout vsync=%b", VSYNC); end
    PLAY = 1'b0;
    force dut.addr_d = 19'h7FFFE;
    @(posedge clk);
    #1 release dut.addr_d;
    capture(60, 0);
    h0 = first_hs(0);
    if (h0 < 1) h0 = 1;
    checks++; if (s_addr[h0-1] !== 19'h7FFFE) begin errors++; $display("FAIL wrap_addr0 got %h want 7fffe", s_addr[h0-1]); end
    checks++; if (s_addr[h0] !== 19'h7FFFF) begin errors++; $display("FAIL wrap_addr1 got %h want 7ffff", s_addr[h0]); end
    checks++; if (s_addr[h0+4] !== 19'h00000) begin errors++; $display("FAIL wrap_addr2 got %h want 00000", s_addr[h0+4]); end
    checks++; if (s_pix[h0] !== exp_pix(8'hFE, 0)) begin errors++; $display("FAIL wrap_pix0 got %h want %h", s_pix[h0], exp_pix(8'hFE, 0)); end
    checks++; if (s_pix[h0+4] !== exp_pix(8'hFF, 1)) begin errors++; $display("FAIL wrap_pix1 got %h want %h", s_pix[h0+4], exp_pix(8'hFF, 1)); end
    checks++; if (s_pix[h0+8] !== exp_pix(8'h00, 2)) begin errors++; $display("FAIL wrap_pix2 got %h want %h", s_pix[h0+8], exp_pix(8'h00, 2)); end
    wait_idle("wrap");
  endtask

  task automatic test_reset_midline();
    int n, rises, v0, h, bseen;
    logic prev;
    @(negedge clk); PLAY = 1'b1;
    n = 0; rises = 0; prev = 1'b0;
    while (rises < 2 && n < 200) begin
      @(negedge clk);
      if (HSYNC && !prev) rises++;
      prev = HSYNC;
      n++;
    end
    checks++; if (rises !== 2) begin errors++; $display("FAIL line2_timeout rises=%0d want 2", rises); end
    repeat (5) @(negedge clk);
    checks++; if ({HSYNC, PIXEL} !== {1'b1, exp_pix(8'h05, 1)}) begin
      errors++; $display("FAIL line2_pixel got hs=%b pix=%h want hs=1 pix=%h", HSYNC, PIXEL, exp_pix(8'h05, 1));
    end
    PLAY = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({HSYNC, VSYNC, PIXEL, BUSY, FRAME_DONE, SRAM_RD_ADDR} !== 31'h0) begin
      errors++; $display("FAIL async_reset hs=%b vs=%b pix=%h busy=%b fd=%b addr=%h want all 0",
                         HSYNC, VSYNC, PIXEL, BUSY, FRAME_DONE, SRAM_RD_ADDR);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bseen = 0;
    repeat (20) begin @(negedge clk); if (BUSY) bseen++; end
    checks++; if (bseen !== 0) begin errors++; $display("FAIL no_resume busy clocks=%0d want 0", bseen); end
    @(negedge clk); PLAY = 1'b1;
    capture(40, 10);
    v0 = first_vs(0, 1'b1);
    h = first_hs(v0);
    checks++; if (v0 !== 3) begin errors++; $display("FAIL restart_latency got %0d want 3", v0); end
    checks++; if (s_addr[v0] !== 19'h0) begin errors++; $display("FAIL restart_addr got %h want 0", s_addr[v0]); end
    checks++; if (s_pix[h] !== exp_pix(8'h00, 0)) begin errors++; $display("FAIL restart_pix0 got %h want %h", s_pix[h], exp_pix(8'h00, 0)); end
    wait_idle("restart");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_addr_wrap();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
